// File: rtl/mips_id_stage.sv
// mips_id_stage: MIPS instruction-decode stage.
//   Holds the register file, decodes destination register / write enable /
//   immediate extension, and registers the results into an ID/EX register
//   with a valid/ready handshake. The WB stage writes through a single port
//   that is bypassed onto same-cycle reads and onto a held ID/EX entry.
// Optional feature macro: ID_HAZARD_EN (load-use stall, one bubble).
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   InValid/InReady/Ins   incoming instruction handshake
//   Flush                 kill held and incoming instruction
//   WbEn/WbAdr/WbData     write-back port
//   OutValid/OutReady     ID/EX register handshake
//   Rdata1/Rdata2/Ed32    rs, rt operands and extended immediate
//   Wadr/WrEn             destination register and its write enable
//   Opcode/Funct          Ins[31:26] / Ins[5:0] passed through
module mips_id_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int ZERO_REG = 1,
  localparam int RA_W    = $clog2(REG_NUM)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Ins,
  input  logic              Flush,
  input  logic              WbEn,
  input  logic [RA_W-1:0]   WbAdr,
  input  logic [DATA_W-1:0] WbData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] Rdata1,
  output logic [DATA_W-1:0] Rdata2,
  output logic [DATA_W-1:0] Ed32,
  output logic [RA_W-1:0]   Wadr,
  output logic              WrEn,
  output logic [5:0]        Opcode,
  output logic [5:0]        Funct
);

  localparam logic [5:0] OP_RFORM = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] ed32;
    logic [RA_W-1:0]   wadr;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic              wren;
    logic [5:0]        opcode;
    logic [5:0]        funct;
  } idex_t;

  logic [DATA_W-1:0] rf [REG_NUM];
  idex_t             d, q;
  logic              vld;
  logic              hazard, accept;
  logic [5:0]        op, fn;
  logic [RA_W-1:0]   rs, rt, rd;
  logic              unused_shamt;

  assign op = Ins[31:26];
  assign fn = Ins[5:0];
  assign rs = RA_W'(Ins[25:21]);
  assign rt = RA_W'(Ins[20:16]);
  assign rd = RA_W'(Ins[15:11]);
  assign unused_shamt = ^Ins[10:6];

  // Register 0 is hardwired when ZERO_REG is set.
  function automatic logic is_zero(input logic [RA_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A live write-back targeting this address.
  function automatic logic wb_hit(input logic [RA_W-1:0] a);
    return WbEn && (WbAdr == a) && !is_zero(a);
  endfunction

  function automatic logic [DATA_W-1:0] rd_port(input logic [RA_W-1:0] a);
    if (is_zero(a))             return '0;
    else if (wb_hit(a))         return WbData;
    else if (int'(a) < REG_NUM) return rf[a];
    else                        return '0;
  endfunction

  // Register file write port; independent of Flush and the handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
    end else if (WbEn && !is_zero(WbAdr) && int'(WbAdr) < REG_NUM) begin
      rf[WbAdr] <= WbData;
    end
  end

  // Decode
  always_comb begin
    d        = '0;
    d.rs     = rs;
    d.rt     = rt;
    d.opcode = op;
    d.funct  = fn;
    d.rdata1 = rd_port(rs);
    d.rdata2 = rd_port(rt);
    d.wadr   = rt;
    d.wren   = 1'b0;
    case (op)
      OP_RFORM: begin d.wadr = rd;             d.wren = (fn != FN_JR); end
      OP_JAL:   begin d.wadr = RA_W'(5'd31);   d.wren = 1'b1;          end
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F,
      OP_LW:    d.wren = 1'b1;
      default:  d.wren = 1'b0;
    endcase
    // Only the logical immediates are zero-extended; LUI (0x0F) is not.
    if (op >= 6'h0C && op <= 6'h0E) d.ed32 = DATA_W'(Ins[15:0]);
    else                            d.ed32 = DATA_W'($signed(Ins[15:0]));
  end

`ifdef ID_HAZARD_EN
  // Load-use: the held LW's result is not yet available to this instruction.
  logic uses_rt;
  assign uses_rt = (op == OP_RFORM) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  assign hazard  = vld && (q.opcode == OP_LW) && (q.wadr != '0) &&
                   ((rs == q.wadr) || (uses_rt && (rt == q.wadr)));
`else
  assign hazard = 1'b0;
`endif

  assign InReady = (!vld || OutReady) && !hazard;
  assign accept  = InValid && InReady && !Flush;

  // ID/EX register
  always_ff @(posedge CLK) begin
    if (RST) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (Flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      q   <= d;
      vld <= 1'b1;
    end else if (OutReady) begin
      vld <= 1'b0;
    end else if (vld) begin
      // Stalled entry: pick up write-backs to its sources so EX sees fresh data.
      if (wb_hit(q.rs)) q.rdata1 <= WbData;
      if (wb_hit(q.rt)) q.rdata2 <= WbData;
    end
  end

  assign OutValid = vld;
  assign Rdata1   = q.rdata1;
  assign Rdata2   = q.rdata2;
  assign Ed32     = q.ed32;
  assign Wadr     = q.wadr;
  assign WrEn     = q.wren;
  assign Opcode   = q.opcode;
  assign Funct    = q.funct;

endmodule

// File: tb/tb_mips_id_stage.sv
// tb_mips_id_stage: directed testbench for mips_id_stage (default parameters).
module tb_mips_id_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] Ins = '0;
  logic        Flush = 1'b0;
  logic        WbEn = 1'b0;
  logic [4:0]  WbAdr = '0;
  logic [31:0] WbData = '0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] Rdata1, Rdata2, Ed32;
  logic [4:0]  Wadr;
  logic        WrEn;
  logic [5:0]  Opcode, Funct;

  int n_tests = 0;
  int n_fail  = 0;

  mips_id_stage dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady), .Ins(Ins),
    .Flush(Flush), .WbEn(WbEn), .WbAdr(WbAdr), .WbData(WbData),
    .OutValid(OutValid), .OutReady(OutReady), .Rdata1(Rdata1), .Rdata2(Rdata2),
    .Ed32(Ed32), .Wadr(Wadr), .WrEn(WrEn), .Opcode(Opcode), .Funct(Funct)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Decode vectors: instruction, expected Ed32, Wadr, WrEn
  localparam int NV = 11;
  logic [31:0] tv_ins [NV] = '{32'h2005FFFD, 32'h34068000, 32'hAC410004, 32'h03E00008,
                               32'h0C000100, 32'h1022FFFF, 32'h8C240000, 32'h3023FFFF,
                               32'h2823FFFF, 32'h3C23FFFF, 32'h3823FFFF};
  logic [31:0] tv_ed  [NV] = '{32'hFFFFFFFD, 32'h00008000, 32'h00000004, 32'h00000008,
                               32'h00000100, 32'hFFFFFFFF, 32'h00000000, 32'h0000FFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF};
  logic [4:0]  tv_wa  [NV] = '{5'd5, 5'd6, 5'd1, 5'd0, 5'd31, 5'd2, 5'd4, 5'd3, 5'd3, 5'd3, 5'd3};
  logic        tv_we  [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset OutValid got %b exp 0", OutValid); end
    n_tests++; if (Rdata1 !== 32'h0 || Rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset Rdata got %h/%h exp 0/0", Rdata1, Rdata2); end
    n_tests++; if (Ed32 !== 32'h0 || Wadr !== 5'd0 || WrEn !== 1'b0) begin n_fail++; $display("FAIL reset Ed32/Wadr/WrEn got %h/%0d/%b exp 0/0/0", Ed32, Wadr, WrEn); end
    n_tests++; if (Opcode !== 6'h0 || Funct !== 6'h0) begin n_fail++; $display("FAIL reset Opcode/Funct got %h/%h exp 0/0", Opcode, Funct); end
    n_tests++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL reset InReady got %b exp 1", InReady); end
    RST = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] w;
    OutReady = 1'b1;
    for (int i = 0; i < NV; i++) begin
      w = tv_ins[i];
      Ins = w;
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      n_tests++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL decode[%0d] OutValid got %b exp 1", i, OutValid); end
      n_tests++; if (Ed32 !== tv_ed[i]) begin n_fail++; $display("FAIL decode[%0d] Ed32 got %h exp %h", i, Ed32, tv_ed[i]); end
      n_tests++; if (Wadr !== tv_wa[i]) begin n_fail++; $display("FAIL decode[%0d] Wadr got %0d exp %0d", i, Wadr, tv_wa[i]); end
      n_tests++; if (WrEn !== tv_we[i]) begin n_fail++; $display("FAIL decode[%0d] WrEn got %b exp %b", i, WrEn, tv_we[i]); end
      n_tests++; if (Opcode !== w[31:26] || Funct !== w[5:0]) begin n_fail++; $display("FAIL decode[%0d] Opcode/Funct got %h/%h exp %h/%h", i, Opcode, Funct, w[31:26], w[5:0]); end
      n_tests++; if (Rdata1 !== 32'h0) begin n_fail++; $display("FAIL decode[%0d] Rdata1 got %h exp 0", i, Rdata1); end
    end
    step();
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL decode drain OutValid got %b exp 0", OutValid); end
  endtask

  task automatic test_bypass();
    // ADD r8,r7,r7 accepted in the same cycle r7 is written back
    Ins = 32'h00E74020; InValid = 1'b1;
    WbEn = 1'b1; WbAdr = 5'd7; WbData = 32'h12345678;
    step();
    InValid = 1'b0; WbEn = 1'b0;
    n_tests++; if (Rdata1 !== 32'h12345678 || Rdata2 !== 32'h12345678) begin n_fail++; $display("FAIL bypass rs/rt got %h/%h exp 12345678/12345678", Rdata1, Rdata2); end
    // ADD r8,r0,r7 while writing r0: r0 stays 0, r7 comes from the file
    Ins = 32'h00074020; InValid = 1'b1;
    WbEn = 1'b1; WbAdr = 5'd0; WbData = 32'h000000FF;
    step();
    InValid = 1'b0; WbEn = 1'b0;
    n_tests++; if (Rdata1 !== 32'h0) begin n_fail++; $display("FAIL bypass_r0 Rdata1 got %h exp 0", Rdata1); end
    n_tests++; if (Rdata2 !== 32'h12345678) begin n_fail++; $display("FAIL rf_write r7 got %h exp 12345678", Rdata2); end
    Ins = 32'h00074020; InValid = 1'b1;
    step();
    InValid = 1'b0;
    n_tests++; if (Rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_later Rdata1 got %h exp 0", Rdata1); end
    step();
  endtask

  task automatic test_hold();
    // ADD r8,r7,r0 held with OutReady low
    Ins = 32'h00E04020; InValid = 1'b1; OutReady = 1'b0;
    step();
    InValid = 1'b0;
    n_tests++; if (OutValid !== 1'b1 || Rdata1 !== 32'h12345678) begin n_fail++; $display("FAIL hold_load OutValid/Rdata1 got %b/%h exp 1/12345678", OutValid, Rdata1); end
    Ins = 32'h2005FFFD; InValid = 1'b1;
    WbEn = 1'b1; WbAdr = 5'd7; WbData = 32'hA5A5A5A5;
    #1;
    n_tests++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL hold InReady got %b exp 0", InReady); end
    step();
    InValid = 1'b0; WbEn = 1'b0;
    n_tests++; if (Rdata1 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL hold_refresh Rdata1 got %h exp a5a5a5a5", Rdata1); end
    n_tests++; if (Rdata2 !== 32'h0) begin n_fail++; $display("FAIL hold_refresh Rdata2 got %h exp 0", Rdata2); end
    n_tests++; if (OutValid !== 1'b1 || Opcode !== 6'h00 || Ed32 !== 32'h00004020) begin n_fail++; $display("FAIL hold_keep OutValid/Opcode/Ed32 got %b/%h/%h exp 1/00/00004020", OutValid, Opcode, Ed32); end
    OutReady = 1'b1;
    step();
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL hold_release OutValid got %b exp 0", OutValid); end
  endtask

  task automatic test_flush();
    Ins = 32'h2005FFFD; InValid = 1'b1; OutReady = 1'b0;
    step();
    n_tests++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL flush_setup OutValid got %b exp 1", OutValid); end
    // OutReady high so only Flush blocks the ORI
    Flush = 1'b1; Ins = 32'h34068000; InValid = 1'b1; OutReady = 1'b1;
    WbEn = 1'b1; WbAdr = 5'd10; WbData = 32'hCAFEF00D;
    step();
    Flush = 1'b0; InValid = 1'b0; WbEn = 1'b0;
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL flush OutValid got %b exp 0", OutValid); end
    step();
    n_tests++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL flush_drop OutValid got %b exp 0", OutValid); end
    Ins = 32'h01404020; InValid = 1'b1;
    step();
    InValid = 1'b0;
    n_tests++; if (OutValid !== 1'b1 || Rdata1 !== 32'hCAFEF00D || Opcode !== 6'h00) begin n_fail++; $display("FAIL flush_wb OutValid/Rdata1/Opcode got %b/%h/%h exp 1/cafef00d/00", OutValid, Rdata1, Opcode); end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_ready;
`ifdef ID_HAZARD_EN
    exp_ready = 1'b0;
`else
    exp_ready = 1'b1;
`endif
    OutReady = 1'b1;
    Ins = 32'h8C240000; InValid = 1'b1;
    step();
    n_tests++; if (OutValid !== 1'b1 || Opcode !== 6'h23) begin n_fail++; $display("FAIL b2b_lw OutValid/Opcode got %b/%h exp 1/23", OutValid, Opcode); end
    // ADD r9,r4,r2 right behind the LW; r4 arrives from WB
    Ins = 32'h00824820; WbEn = 1'b1; WbAdr = 5'd4; WbData = 32'h00000044;
    #1;
    n_tests++; if (InReady !== exp_ready) begin n_fail++; $display("FAIL b2b InReady got %b exp %b", InReady, exp_ready); end
    step();
    n_tests++; if (OutValid !== exp_ready) begin n_fail++; $display("FAIL b2b second OutValid got %b exp %b", OutValid, exp_ready); end
    if (!exp_ready) begin
      n_tests++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL bubble InReady got %b exp 1", InReady); end
      step();
    end
    InValid = 1'b0; WbEn = 1'b0;
    n_tests++; if (OutValid !== 1'b1 || Opcode !== 6'h00 || Wadr !== 5'd9) begin n_fail++; $display("FAIL b2b_add OutValid/Opcode/Wadr got %b/%h/%0d exp 1/00/9", OutValid, Opcode, Wadr); end
    n_tests++; if (Rdata1 !== 32'h00000044) begin n_fail++; $display("FAIL b2b_add Rdata1 got %h exp 00000044", Rdata1); end
    step();
  endtask

  task automatic test_reset_mid();
    Ins = 32'h00E04020; InValid = 1'b1; OutReady = 1'b0;
    step();
    InValid = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_tests++; if (OutValid !== 1'b0 || Rdata1 !== 32'h0 || Wadr !== 5'd0 || Opcode !== 6'h0 || Funct !== 6'h0) begin n_fail++; $display("FAIL reset_mid OutValid/Rdata1/Wadr/Opcode/Funct got %b/%h/%0d/%h/%h exp 0/0/0/0/0", OutValid, Rdata1, Wadr, Opcode, Funct); end
    OutReady = 1'b1;
    Ins = 32'h00EA4020; InValid = 1'b1;
    step();
    InValid = 1'b0;
    n_tests++; if (Rdata1 !== 32'h0 || Rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset_mid rf r7/r10 got %h/%h exp 0/0", Rdata1, Rdata2); end
    step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_bypass();
    test_hold();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_id_stage.md
Name: mips_id_stage

Overview:
- Parametrised instruction-decode stage for the MIPS core, successor to the single-cycle decode/register-file block.
- Holds the register file, decodes the destination register, write enable and immediate extension, and registers all results into an ID/EX pipeline register with valid/ready handshake.
- Takes the write-back port from the WB stage, with same-cycle write-through bypass and optional load-use hazard stall.

Parameters:
- DATA_W, 32, register and immediate-extension width (>=16).
- REG_NUM, 32, number of architectural registers; address width RA_W = clog2(REG_NUM), and RA_W must be >=5.
- ZERO_REG, 1, when 1 register 0 reads as 0 and writes to it are dropped.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- InValid  in  1  Ins is valid
- InReady  out  1  stage accepts Ins this cycle
- Ins  in  32  instruction word
- Flush  in  1  kill held and incoming instruction
- WbEn  in  1  write-back enable
- WbAdr  in  RA_W  write-back register address
- WbData  in  DATA_W  write-back data
- OutValid  out  1  ID/EX register valid
- OutReady  in  1  EX consumes the ID/EX register
- Rdata1  out  DATA_W  rs operand
- Rdata2  out  DATA_W  rt operand
- Ed32  out  DATA_W  extended immediate
- Wadr  out  RA_W  destination register
- WrEn  out  1  instruction writes the register file
- Opcode  out  6  Ins[31:26] passed through
- Funct  out  6  Ins[5:0] passed through

Behaviour:
- Reset: all registers = 0. OutValid=0. Rdata1, Rdata2, Ed32, Wadr, WrEn, Opcode and Funct = 0.
- Decode, combinational on Ins:
  - R_FORM (0x00): Wadr=rd (Ins[15:11]); WrEn=1 unless Funct=JR (0x08).
  - JAL (0x03): Wadr=31, WrEn=1.
  - 0x08..0x0F: Wadr=rt, WrEn=1.
  - LW (0x23): Wadr=rt, WrEn=1.
  - All other opcodes, including SW (0x2B), branches and J: WrEn=0, Wadr=rt.
- Immediate extension:
  - ANDI/ORI/XORI (0x0C..0x0E): zero-extend Ins[15:0] to DATA_W.
  - All other opcodes: sign-extend.
- Register address width: the 5-bit fields are zero-extended to RA_W.
- Write port:
  - On CLK, if WbEn and not RST, RF[WbAdr] <= WbData.
  - With ZERO_REG=1, WbAdr=0 is ignored.
  - Writes occur regardless of Flush or the handshake.
- Read and bypass: if WbEn and WbAdr equals the source address (and is nonzero when ZERO_REG=1), the read returns WbData instead of RF contents.
- Handshake:
  - InReady = (!OutValid | OutReady) & !hazard.
  - Accept = InValid & InReady & !Flush. On Accept, the ID/EX register loads all decoded fields and operands, and OutValid <= 1.
  - Else if OutReady, OutValid <= 0.
  - Else the register holds its contents.
  - Latency is 1 cycle from accept to OutValid.
- Hold refresh: while OutValid & !OutReady, a WbEn write whose address matches the held rs/rt updates the held Rdata1/Rdata2 in the same edge. Held rs/rt addresses are stored internally.
- Flush: next cycle OutValid=0; an incoming instruction in the Flush cycle is dropped, not accepted. Flush takes priority over Accept and hazard.
- RST mid-operation takes priority over everything: the in-flight instruction is lost and the register file is cleared.
- hazard = 0 unless ID_HAZARD_EN is defined.

Optional Feature:
- Macro: ID_HAZARD_EN.
- Defined: hazard = OutValid & held Opcode==LW & held Wadr!=0 & (rs==held Wadr, or rt==held Wadr for R_FORM/SW/BEQ/BNE).
  - InReady drops. When OutReady retires the LW, OutValid <= 0, giving exactly one bubble.
  - The next cycle accepts the dependent instruction, with its operand taken via WB bypass or RF.
- Undefined: no hazard logic; software schedules load delay slots.

Test Plan:
- Reset, then ADDI r5,r0,-3 (0x2005FFFD), InValid=1, OutReady=1 -> next cycle OutValid=1, Ed32=0xFFFFFFFD, Wadr=5, WrEn=1, Rdata1=0.
- ORI r6,r0,0x8000 -> Ed32=0x00008000. SW r1,4(r2) -> WrEn=0. JR r31 -> WrEn=0. JAL -> Wadr=31, WrEn=1.
- WbEn=1, WbAdr=7, WbData=0x12345678 in the same cycle as accepting ADD r8,r7,r7 -> Rdata1=Rdata2=0x12345678. WbAdr=0, WbData=0xFF -> later read of r0 returns 0.
- Hold with OutReady=0 holding ADD r8,r7,r0, then WB r7=0xA5A5A5A5 -> held Rdata1 becomes 0xA5A5A5A5 with no new accept; InReady=0 while held.
- Flush asserted with OutValid=1 and InValid=1 -> next cycle OutValid=0; the incoming instruction never appears; a concurrent WB write still lands.
- ID_HAZARD_EN defined: LW r4,0(r1) followed by ADD r9,r4,r2 -> InReady=0 for 1 cycle, OutValid sequence 1,0,1. Undefined -> no bubble, OutValid sequence 1,1.
